// File: rtl/keypad_pkg.sv
// Shared types and keymap for the 4x4 keypad encoder.
package keypad_pkg;

    localparam int unsigned KEYS  = 16;
    localparam int unsigned NUM_W = 5;

    localparam logic [NUM_W-1:0] NO_KEY = 5'd31;
    localparam logic [NUM_W-1:0] KEY_A  = 5'd10;
    localparam logic [NUM_W-1:0] KEY_B  = 5'd11;
    localparam logic [NUM_W-1:0] KEY_C  = 5'd12;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    typedef struct packed {
        logic       is_digit;
        logic [3:0] digit;
        logic       is_start;
        logic       is_clear;
        logic       is_enter;
        logic       masked;
    } key_info_t;

    typedef struct packed {
        logic [NUM_W-1:0] num;
        logic             start_set;
        logic             start;
        logic             clear;
        logic             enter;
    } key_out_t;

    // Snapshot index is row*4+col; '*', '#' and D have no function.
    function automatic logic [NUM_W-1:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd0:    key_code = 5'd1;
            4'd1:    key_code = 5'd2;
            4'd2:    key_code = 5'd3;
            4'd3:    key_code = KEY_A;
            4'd4:    key_code = 5'd4;
            4'd5:    key_code = 5'd5;
            4'd6:    key_code = 5'd6;
            4'd7:    key_code = KEY_B;
            4'd8:    key_code = 5'd7;
            4'd9:    key_code = 5'd8;
            4'd10:   key_code = 5'd9;
            4'd11:   key_code = KEY_C;
            4'd13:   key_code = 5'd0;
            default: key_code = NO_KEY;
        endcase
    endfunction

    function automatic key_info_t keymap(input logic [3:0] idx);
        key_info_t        k;
        logic [NUM_W-1:0] c;
        c          = key_code(idx);
        k.is_digit = (c < 5'd10);
        k.digit    = c[3:0];
        k.is_start = (c == KEY_A);
        k.is_clear = (c == KEY_B);
        k.is_enter = (c == KEY_C);
        k.masked   = (c == NO_KEY);
        return k;
    endfunction

    function automatic logic [KEYS-1:0] key_mask();
        logic [KEYS-1:0] m;
        m = '0;
        for (int i = 0; i < int'(KEYS); i++) begin
            m[i] = (key_code(4'(i)) == NO_KEY);
        end
        return m;
    endfunction

    localparam logic [KEYS-1:0] KEY_MASK = key_mask();

    // Output image presented to the controller for an accepted key.
    function automatic key_out_t encode_key(input key_info_t k, input logic [NUM_W-1:0] no_key);
        key_out_t o;
        o.num       = k.is_digit ? {1'b0, k.digit} : no_key;
        o.start_set = ~k.masked;
        o.start     = k.is_start;
        o.clear     = k.is_clear;
        o.enter     = k.is_enter;
        return o;
    endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column drive rotation and row sampling; builds one 16-bit snapshot per sweep.
module keypad_col_scanner #(
    parameter int unsigned SCAN_DIV = 25
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_row,
    output logic [3:0]  o_col,
    output logic [15:0] o_snapshot_c,
    output logic        o_sweep_done_c
);

    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [3:0]        r_row_s1;
    logic [3:0]        r_row_s2;
    logic [SLOT_W-1:0] r_slot;
    logic [1:0]        r_col_idx;
    logic [3:0]        r_col;
    logic [15:0]       r_snap;

    logic              w_slot_last;
    logic [15:0]       w_spread;

    assign w_slot_last = (r_slot == SLOT_W'(SCAN_DIV - 1));

    // Pressed rows (active-low) spread to bit r*4, then shifted to the active column.
    assign w_spread = {3'b000, ~r_row_s2[3], 3'b000, ~r_row_s2[2],
                       3'b000, ~r_row_s2[1], 3'b000, ~r_row_s2[0]};

    assign o_snapshot_c   = r_snap | (w_spread << r_col_idx);
    assign o_sweep_done_c = w_slot_last && (r_col_idx == 2'd3);
    assign o_col          = r_col;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_row_s1  <= 4'hF;
            r_row_s2  <= 4'hF;
            r_slot    <= '0;
            r_col_idx <= '0;
            r_col     <= 4'b1110;
            r_snap    <= '0;
        end else begin
            r_row_s1 <= i_row;
            r_row_s2 <= r_row_s1;
            if (w_slot_last) begin
                r_slot    <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                r_col     <= {r_col[2:0], r_col[3]};
                r_snap    <= o_sweep_done_c ? 16'd0 : o_snapshot_c;
            end else begin
                r_slot <= r_slot + SLOT_W'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner/debouncer presenting one accepted key at a time to the controller.
module keypad_encoder #(
    parameter int unsigned SCAN_DIV       = 25,
    parameter int unsigned DEBOUNCE_SCANS = 5,
    parameter logic [4:0]  NO_KEY         = 5'd31
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] num,
    output logic       startSet,
    output logic       start,
    output logic       clear,
    output logic       enter
);

    import keypad_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cand;
    logic [3:0]       w_cand_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] r_rel_cnt;
    logic [CNT_W-1:0] w_rel_cnt_nxt;
    logic [CNT_W-1:0] w_rel_inc;
    key_out_t         r_out;
    key_out_t         w_out_nxt;
    key_out_t         w_out_load;
    key_out_t         w_out_idle;

    logic [15:0]      w_snapshot;
    logic [15:0]      w_snap_m;
    logic             w_sweep_done;
    logic             w_single;
    logic [3:0]       w_idx;

    keypad_col_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .i_clk          (CLK),
        .i_reset        (reset),
        .i_row          (row),
        .o_col          (col),
        .o_snapshot_c   (w_snapshot),
        .o_sweep_done_c (w_sweep_done)
    );

    assign w_snap_m  = w_snapshot & ~KEY_MASK;
    assign w_single  = (w_snap_m != 16'd0) && ((w_snap_m & (w_snap_m - 16'd1)) == 16'd0);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_rel_inc = r_rel_cnt + CNT_W'(1);

    // Index of the lowest set key; only meaningful when w_single is true.
    always_comb begin
        w_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (w_snap_m[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    assign w_out_load = encode_key(keymap(w_idx), NO_KEY);
    assign w_out_idle = '{num: NO_KEY, default: 1'b0};

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= SCAN;
            r_cand    <= '0;
            r_cnt     <= '0;
            r_rel_cnt <= '0;
            r_out     <= '{num: NO_KEY, default: 1'b0};
        end else begin
            r_state   <= w_state_nxt;
            r_cand    <= w_cand_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rel_cnt <= w_rel_cnt_nxt;
            r_out     <= w_out_nxt;
        end
    end

    // Decisions happen only at sweep end; outputs move only on HOLD entry/exit.
    always_comb begin
        w_state_nxt   = r_state;
        w_cand_nxt    = r_cand;
        w_cnt_nxt     = r_cnt;
        w_rel_cnt_nxt = r_rel_cnt;
        w_out_nxt     = r_out;
        if (w_sweep_done) begin
            case (r_state)
                SCAN: begin
                    if (w_single) begin
                        w_cand_nxt  = w_idx;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = DEBOUNCE;
                        if (DEBOUNCE_SCANS <= 1) begin
                            w_out_nxt     = w_out_load;
                            w_rel_cnt_nxt = '0;
                            w_state_nxt   = HOLD;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (w_snap_m == (16'd1 << r_cand)) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            w_out_nxt     = w_out_load;
                            w_rel_cnt_nxt = '0;
                            w_state_nxt   = HOLD;
                        end
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = SCAN;
                    end
                end
                HOLD: begin
                    if (w_snap_m == 16'd0) begin
                        w_rel_cnt_nxt = w_rel_inc;
                        if (w_rel_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            w_out_nxt     = w_out_idle;
                            w_rel_cnt_nxt = '0;
                            w_cnt_nxt     = '0;
                            w_state_nxt   = SCAN;
                        end
                    end else begin
                        w_rel_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = SCAN;
                end
            endcase
        end
    end

    assign num      = r_out.num;
    assign startSet = r_out.start_set;
    assign start    = r_out.start;
    assign clear    = r_out.clear;
    assign enter    = r_out.enter;

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder: keypad model drives rows, output changes are matched against expected events.
module tb_keypad_encoder;

    localparam int SWEEP = 16;
    localparam int LAT   = 3 * SWEEP;

    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  num;
        logic        ss;
        logic        st;
        logic        cl;
        logic        en;
    } ev_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [4:0]  num;
    logic        startSet, start, clear, enter;
    logic [15:0] keys = 16'd0;
    logic [8:0]  prev = 'x;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    ev_t         exp_q[$];
    ev_t         obs_q[$];

    keypad_encoder #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .NO_KEY         (5'd31)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .num      (num),
        .startSet (startSet),
        .start    (start),
        .clear    (clear),
        .enter    (enter)
    );

    always #5 CLK = ~CLK;

    // Passive matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col[c] == 1'b0 && keys[r*4+c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge CLK) cyc <= reset ? 0 : cyc + 1;

    function automatic ev_t mk(input int c, input logic [4:0] n, input logic ss,
                               input logic st, input logic cl, input logic en);
        return {32'(c), n, ss, st, cl, en};
    endfunction

    always @(negedge CLK) begin
        if ({startSet, num, start, clear, enter} !== prev) begin
            obs_q.push_back(mk(cyc, num, startSet, start, clear, enter));
            prev = {startSet, num, start, clear, enter};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog");
    end

    task automatic align();
        while (cyc % SWEEP != 0 || cyc == 0) @(negedge CLK);
    endtask

    task automatic apply(input logic [15:0] k, input int n, output int t0);
        align();
        keys = k;
        t0 = cyc;
        repeat (n * SWEEP) @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        reset = 1'b1;
        @(negedge CLK);
        total += 4;
        if (col !== 4'b1110) begin bad++; $display("FAIL reset_col: got %b want 1110", col); end
        if (num !== 5'd31) begin bad++; $display("FAIL reset_num: got %0d want 31", num); end
        if (startSet !== 1'b0) begin bad++; $display("FAIL reset_startSet: got %b want 0", startSet); end
        if ({start, clear, enter} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {start, clear, enter});
        end
        @(negedge CLK);
        reset = 1'b0;
        for (int i = 0; i < 2 * SWEEP; i++) begin
            @(negedge CLK);
            exp_col = 4'b0001 << ((cyc / 4) % 4);
            exp_col = ~exp_col;
            total++;
            if (col !== exp_col) begin
                bad++; $display("FAIL col_rotation: cyc=%0d got %b want %b", cyc, col, exp_col);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_digit();
        string nm = "digit_7";
        ev_t e, o;
        int t;
        apply(16'h0001 << 8, 5, t);
        exp_q.push_back(mk(t + LAT, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(16'h0000, 4, t);
        exp_q.push_back(mk(t + LAT, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL %s event: got none want cyc=%0d num=%0d ss=%b st=%b cl=%b en=%b", nm, e.cyc, e.num, e.ss, e.st, e.cl, e.en);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++; $display("FAIL %s event: got cyc=%0d num=%0d ss=%b st=%b cl=%b en=%b want cyc=%0d num=%0d ss=%b st=%b cl=%b en=%b", nm, o.cyc, o.num, o.ss, o.st, o.cl, o.en, e.cyc, e.num, e.ss, e.st, e.cl, e.en);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL %s extra: got %0d events want 0", nm, obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_bounce();
        string nm = "bounce_5";
        ev_t e, o;
        int t;
        apply(16'h0001 << 5, 1, t);
        apply(16'h0000, 1, t);
        apply(16'h0001 << 5, 1, t);
        apply(16'h0000, 1, t);
        apply(16'h0001 << 5, 5, t);
        exp_q.push_back(mk(t + LAT, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(16'h0000, 4, t);
        exp_q.push_back(mk(t + LAT, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL %s event: got none want cyc=%0d num=%0d ss=%b", nm, e.cyc, e.num, e.ss);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++; $display("FAIL %s event: got cyc=%0d num=%0d ss=%b st=%b cl=%b en=%b want cyc=%0d num=%0d ss=%b st=%b cl=%b en=%b", nm, o.cyc, o.num, o.ss, o.st, o.cl, o.en, e.cyc, e.num, e.ss, e.st, e.cl, e.en);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL %s extra: got %0d events want 0", nm, obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_func_keys();
        string nm = "func_keys";
        int fk[3] = '{3, 7, 11};
        int mk_idx[3] = '{12, 14, 15};
        ev_t e, o;
        int t;
        for (int i = 0; i < 3; i++) begin
            apply(16'h0001 << fk[i], 5, t);
            exp_q.push_back(mk(t + LAT, 5'd31, 1'b1, i == 0, i == 1, i == 2));
            apply(16'h0000, 4, t);
            exp_q.push_back(mk(t + LAT, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        for (int i = 0; i < 3; i++) begin
            apply(16'h0001 << mk_idx[i], 5, t);
            apply(16'h0000, 1, t);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL %s event: got none want cyc=%0d st=%b cl=%b en=%b", nm, e.cyc, e.st, e.cl, e.en);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++; $display("FAIL %s event: got cyc=%0d num=%0d ss=%b st=%b cl=%b en=%b want cyc=%0d num=%0d ss=%b st=%b cl=%b en=%b", nm, o.cyc, o.num, o.ss, o.st, o.cl, o.en, e.cyc, e.num, e.ss, e.st, e.cl, e.en);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL %s masked_extra: got %0d events want 0", nm, obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_multi_key();
        string nm = "multi_key";
        ev_t e, o;
        int t;
        apply(16'h0003, 5, t);
        apply(16'h0004, 5, t);
        exp_q.push_back(mk(t + LAT, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(16'h0404, 4, t);
        apply(16'h0000, 4, t);
        exp_q.push_back(mk(t + LAT, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL %s event: got none want cyc=%0d num=%0d ss=%b", nm, e.cyc, e.num, e.ss);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++; $display("FAIL %s event: got cyc=%0d num=%0d ss=%b st=%b cl=%b en=%b want cyc=%0d num=%0d ss=%b st=%b cl=%b en=%b", nm, o.cyc, o.num, o.ss, o.st, o.cl, o.en, e.cyc, e.num, e.ss, e.st, e.cl, e.en);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL %s extra: got %0d events want 0", nm, obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_reset_in_hold();
        string nm = "reset_in_hold";
        ev_t e, o;
        int t;
        apply(16'h0004, 4, t);
        exp_q.push_back(mk(t + LAT, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        exp_q.push_back(mk(0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(LAT, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (4 * SWEEP) @(negedge CLK);
        keys = 16'h0000;
        exp_q.push_back(mk(4 * SWEEP + LAT, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (4 * SWEEP) @(negedge CLK);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL %s event: got none want cyc=%0d num=%0d ss=%b", nm, e.cyc, e.num, e.ss);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++; $display("FAIL %s event: got cyc=%0d num=%0d ss=%b st=%b cl=%b en=%b want cyc=%0d num=%0d ss=%b st=%b cl=%b en=%b", nm, o.cyc, o.num, o.ss, o.st, o.cl, o.en, e.cyc, e.num, e.ss, e.st, e.cl, e.en);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL %s extra: got %0d events want 0", nm, obs_q.size()); end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_digit();
        test_bounce();
        test_func_keys();
        test_multi_key();
        test_reset_in_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
